// File: rtl/aes_inv_controller_if.sv
// Control bundle between the inverse-AES controller and its datapath/host.
interface aes_inv_controller_if;
   logic       load;
   logic       busy;
   logic       done;
   logic [3:0] round;
   logic       key_dir;
   logic       key_en;
   logic       state_en;
   logic       sel_init;
   logic       sel_final;

   // Host/datapath side: issues load, observes status and enables.
   modport master (
      output load,
      input  busy, done, round, key_dir, key_en, state_en, sel_init, sel_final
   );

   // Controller side.
   modport slave (
      input  load,
      output busy, done, round, key_dir, key_en, state_en, sel_init, sel_final
   );
endinterface

// File: rtl/aes_inv_controller.sv
// Inverse-AES sequencing FSM: forward key expansion to the last round key,
// initial AddRoundKey, nine inverse rounds while walking the key schedule
// backwards, then a final round without InvMixColumns. Each key/round step
// is stretched by WAIT_CYCLES to absorb the registered S-box latency.
module aes_inv_controller #(
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   aes_inv_controller_if.slave  bus
);

   localparam int unsigned CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
   localparam int unsigned RND_W = 4;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(WAIT_CYCLES);
   localparam logic [RND_W-1:0] RND_FIRST = RND_W'(1);
   localparam logic [RND_W-1:0] RND_LAST  = RND_W'(10);
   localparam logic [RND_W-1:0] RND_INV0  = RND_W'(9);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_KEYEXP = 3'd1,
      S_INIT   = 3'd2,
      S_ROUND  = 3'd3,
      S_FINAL  = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [RND_W-1:0] round_q, round_d;

   logic busy_q, busy_d;
   logic done_q, done_d;
   logic key_dir_q, key_dir_d;
   logic key_en_q, key_en_d;
   logic state_en_q, state_en_d;
   logic sel_init_q, sel_init_d;
   logic sel_final_q, sel_final_d;

   logic step_last;
   logic step_last_d;

   // Next state, step counter and round index; outputs are decoded from the
   // next-state values so they can be registered without adding latency.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      round_d     = round_q;
      step_last   = (cnt_q == CNT_LAST);

      case (state_q)
         S_IDLE, S_DONE: begin
            if (bus.load) begin
               state_d = S_KEYEXP;
               round_d = RND_FIRST;
               cnt_d   = '0;
            end
         end
         S_KEYEXP: begin
            if (step_last) begin
               cnt_d = '0;
               if (round_q == RND_LAST) state_d = S_INIT;
               else                     round_d = round_q + RND_W'(1);
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_INIT: begin
            state_d = S_ROUND;
            round_d = RND_INV0;
            cnt_d   = '0;
         end
         S_ROUND: begin
            if (step_last) begin
               cnt_d = '0;
               if (round_q == RND_FIRST) begin
                  state_d = S_FINAL;
                  round_d = '0;
               end else begin
                  round_d = round_q - RND_W'(1);
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_FINAL: begin
            if (step_last) begin
               state_d = S_DONE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
            round_d = '0;
         end
      endcase

      step_last_d = (cnt_d == CNT_LAST);
      busy_d      = (state_d == S_KEYEXP) || (state_d == S_INIT) ||
                    (state_d == S_ROUND)  || (state_d == S_FINAL);
      done_d      = (state_d == S_DONE);
      key_dir_d   = (state_d == S_ROUND) || (state_d == S_FINAL);
      key_en_d    = ((state_d == S_KEYEXP) || (state_d == S_ROUND)) && step_last_d;
      state_en_d  = (state_d == S_INIT) ||
                    (((state_d == S_ROUND) || (state_d == S_FINAL)) && step_last_d);
      sel_init_d  = (state_d == S_INIT);
      sel_final_d = (state_d == S_FINAL);
   end

   // State, counters and registered outputs; reset wins over everything.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         round_q     <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         key_dir_q   <= 1'b0;
         key_en_q    <= 1'b0;
         state_en_q  <= 1'b0;
         sel_init_q  <= 1'b0;
         sel_final_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         round_q     <= round_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         key_dir_q   <= key_dir_d;
         key_en_q    <= key_en_d;
         state_en_q  <= state_en_d;
         sel_init_q  <= sel_init_d;
         sel_final_q <= sel_final_d;
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.round     = round_q;
   assign bus.key_dir   = key_dir_q;
   assign bus.key_en    = key_en_q;
   assign bus.state_en  = state_en_q;
   assign bus.sel_init  = sel_init_q;
   assign bus.sel_final = sel_final_q;

endmodule

// File: tb/tb_aes_inv_controller.sv
// Bench for aes_inv_controller: default and zero-wait instances checked
// cycle by cycle against a phase-arithmetic reference model.
module tb_aes_inv_controller;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   aes_inv_controller_if bus2 ();
   aes_inv_controller_if bus0 ();

   aes_inv_controller #(.WAIT_CYCLES(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus2.slave)
   );

   aes_inv_controller #(.WAIT_CYCLES(0)) dut_w0 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus0.slave)
   );

   int errors = 0;
   int checks = 0;
   int n_key_fwd, n_key_inv, n_state, n_state_fin, n_state_ini;

   // Vector layout: {busy, done, round[3:0], key_dir, key_en, state_en, sel_init, sel_final}
   localparam logic [10:0] IDLE_VEC = 11'h000;
   localparam logic [10:0] DONE_VEC = 11'h200;

   // Expected outputs in the cycle that follows the p-th edge after load was sampled.
   function automatic logic [10:0] model(int w, int p);
      int s   = w + 1;
      int kx  = 10 * s;
      int q   = 0;
      int rnd = 0;
      logic busy = 0, done = 0, kd = 0, ke = 0, se = 0, si = 0, sf = 0;
      if (p < kx) begin
         busy = 1; rnd = p / s + 1; ke = ((p % s) == w);
      end else if (p == kx) begin
         busy = 1; rnd = 10; se = 1; si = 1;
      end else if (p <= kx + 9 * s) begin
         q = p - kx - 1;
         busy = 1; kd = 1; rnd = 9 - q / s;
         ke = ((q % s) == w); se = ke;
      end else if (p <= 20 * s) begin
         busy = 1; kd = 1; sf = 1; rnd = 0; se = (p == 20 * s);
      end else begin
         done = 1;
      end
      return {busy, done, 4'(rnd), kd, ke, se, si, sf};
   endfunction

   function automatic logic [10:0] obs(int w);
      if (w == 0)
         return {bus0.busy, bus0.done, bus0.round, bus0.key_dir, bus0.key_en,
                 bus0.state_en, bus0.sel_init, bus0.sel_final};
      return {bus2.busy, bus2.done, bus2.round, bus2.key_dir, bus2.key_en,
              bus2.state_en, bus2.sel_init, bus2.sel_final};
   endfunction

   task automatic drive_load(int w, logic v);
      if (w == 0) bus0.load = v;
      else        bus2.load = v;
   endtask

   task automatic chk(string tag, logic [10:0] o, logic [10:0] e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, o, e);
      end
   endtask

   task automatic chk_n(string tag, int o, int e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
      end
   endtask

   // Assumes load=1 is already driven; the first edge below samples it.
   // mode 0: random load noise while busy; mode 1: load held high.
   task automatic run_op(int w, int mode, logic keep_load, int last_p);
      int lat = 20 * (w + 1) + 1;
      logic [10:0] o;
      n_key_fwd = 0; n_key_inv = 0; n_state = 0; n_state_fin = 0; n_state_ini = 0;
      for (int p = 0; p <= last_p; p++) begin
         @(posedge clk);
         #1;
         o = obs(w);
         chk($sformatf("w%0d_p%0d", w, p), o, model(w, p));
         if (o[3] && !o[4]) n_key_fwd++;
         if (o[3] &&  o[4]) n_key_inv++;
         if (o[2])          n_state++;
         if (o[2] && o[0])  n_state_fin++;
         if (o[2] && o[1])  n_state_ini++;
         if (p < lat) drive_load(w, (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1)));
         else         drive_load(w, keep_load);
      end
      if (last_p >= lat) begin
         chk_n($sformatf("w%0d_key_fwd_pulses", w), n_key_fwd, 10);
         chk_n($sformatf("w%0d_key_inv_pulses", w), n_key_inv, 9);
         chk_n($sformatf("w%0d_state_pulses", w), n_state, 11);
         chk_n($sformatf("w%0d_state_final_pulses", w), n_state_fin, 1);
         chk_n($sformatf("w%0d_state_init_pulses", w), n_state_ini, 1);
      end
   endtask

   task automatic idle_cycles(int w, int n, logic [10:0] e, string tag);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         chk($sformatf("%s_%0d", tag, i), obs(w), e);
      end
   endtask

   initial begin
      reset = 1'b1;
      drive_load(2, 1'b1);
      drive_load(0, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      chk("reset_w2", obs(2), IDLE_VEC);
      chk("reset_w0", obs(0), IDLE_VEC);
      reset = 1'b0;
      drive_load(2, 1'b0);
      drive_load(0, 1'b0);
      idle_cycles(2, int'($urandom_range(1, 4)), IDLE_VEC, "idle_after_reset");

      // Single load pulse, random load noise while busy, then sit in DONE.
      drive_load(2, 1'b1);
      run_op(2, 0, 1'b0, 61);
      idle_cycles(2, 3, DONE_VEC, "done_hold");

      // Load held high: no restart while busy, back-to-back restart from DONE.
      drive_load(2, 1'b1);
      run_op(2, 1, 1'b1, 61);
      run_op(2, 1, 1'b0, 61);
      idle_cycles(2, 2, DONE_VEC, "done_hold2");

      // Reset in the middle of ROUND (round 6) with load also asserted.
      drive_load(2, 1'b1);
      run_op(2, 0, 1'b0, 40);
      reset = 1'b1;
      drive_load(2, 1'b1);
      @(posedge clk);
      #1;
      chk("reset_mid_op", obs(2), IDLE_VEC);
      reset = 1'b0;
      drive_load(2, 1'b0);
      idle_cycles(2, 3, IDLE_VEC, "idle_after_mid_reset");
      drive_load(2, 1'b1);
      run_op(2, 0, 1'b0, 61);

      // Zero-wait instance.
      idle_cycles(0, 2, IDLE_VEC, "w0_idle");
      drive_load(0, 1'b1);
      run_op(0, 0, 1'b0, 21);
      idle_cycles(0, 2, DONE_VEC, "w0_done_hold");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
